// File: rtl/program_loader_if.sv
// Byte-stream loader bus: UART receive strobe in, instruction-memory writes and CPU FIFO pushes out.
// The loader side uses the slave modport; the environment drives rdata/rdata_ready/ferr through master.
interface program_loader_if #(
   parameter int ADDR_W = 14
);
   logic [7:0]        rdata;
   logic              rdata_ready;
   logic              ferr;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              fifo_we;
   logic [7:0]        fifo_wdata;
   logic              load_done;
   logic              err;

   modport master (
      output rdata, rdata_ready, ferr,
      input  imem_we, imem_addr, imem_wdata, fifo_we, fifo_wdata, load_done, err
   );

   modport slave (
      input  rdata, rdata_ready, ferr,
      output imem_we, imem_addr, imem_wdata, fifo_we, fifo_wdata, load_done, err
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: 4-byte big-endian size, then little-endian program words into imem, then bytes to CPU FIFO.
// Writes and pushes appear one cycle after the accepting strobe; no backpressure, every good strobe is taken.
module program_loader #(
   parameter int ADDR_W    = 14,
   parameter int BASE_ADDR = 0
) (
   input logic             clk,
   input logic             rstn,
   program_loader_if.slave bus
);
   typedef enum logic [1:0] {ST_SIZE, ST_PROG, ST_RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        size_idx;
   logic [23:0]       size_hi;
   logic [31:0]       remaining;
   logic [1:0]        byte_idx;
   logic [31:0]       word_buf;
   logic [ADDR_W-1:0] word_idx;
   logic              wrapped;

   logic              strobe;
   logic              write;
   logic              push;
   logic              last;
   logic [31:0]       size_word;
   logic [31:0]       word_nxt;

   assign strobe    = bus.rdata_ready & ~bus.ferr;
   assign size_word = {size_hi, bus.rdata};
   assign last      = (remaining == 32'd1);
   // Lane 0 starts a fresh word so a short final group is zero-padded above the last byte.
   assign word_nxt  = ((byte_idx == 2'd0) ? 32'd0 : word_buf) |
                      ({24'd0, bus.rdata} << {byte_idx, 3'b000});

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_SIZE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      write     = 1'b0;
      push      = 1'b0;
      case (state)
         ST_SIZE: begin
            if (strobe && size_idx == 2'd3) begin
               state_nxt = (size_word == 32'd0) ? ST_RUN : ST_PROG;
            end
         end
         ST_PROG: begin
            if (strobe) begin
               write = (byte_idx == 2'd3) || last;
               if (last) begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            push = strobe;
         end
         default: begin
            state_nxt = ST_SIZE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         size_idx       <= 2'd0;
         size_hi        <= 24'd0;
         remaining      <= 32'd0;
         byte_idx       <= 2'd0;
         word_buf       <= 32'd0;
         word_idx       <= '0;
         wrapped        <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= ADDR_W'(BASE_ADDR);
         bus.imem_wdata <= 32'd0;
         bus.fifo_we    <= 1'b0;
         bus.fifo_wdata <= 8'd0;
         bus.load_done  <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.imem_we   <= write;
         bus.fifo_we   <= push;
         bus.load_done <= (state_nxt == ST_RUN);
         if (bus.rdata_ready && bus.ferr) begin
            bus.err <= 1'b1;
         end
         if (push) begin
            bus.fifo_wdata <= bus.rdata;
         end
         if (state == ST_SIZE && strobe) begin
            size_hi   <= size_word[23:0];
            size_idx  <= size_idx + 2'd1;
            remaining <= size_word;
         end
         if (state == ST_PROG && strobe) begin
            remaining <= remaining - 32'd1;
            byte_idx  <= byte_idx + 2'd1;
            word_buf  <= word_nxt;
            if (write) begin
               bus.imem_addr  <= ADDR_W'(BASE_ADDR) + word_idx;
               bus.imem_wdata <= word_nxt;
               word_idx       <= word_idx + ADDR_W'(1);
               // A program larger than the memory is flagged on the first write that lands on a reused address.
               if (&word_idx) begin
                  wrapped <= 1'b1;
               end
               if (wrapped) begin
                  bus.err <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Drives one byte stream into two loaders (wide memory, and a 4-word memory at a nonzero base)
// and compares every cycle against a model computed from the accepted-byte history.
module tb_program_loader;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] rdata = 8'd0;
   logic       rdata_ready = 1'b0;
   logic       ferr = 1'b0;

   always #5 clk = ~clk;

   program_loader_if #(.ADDR_W(14)) bus_a ();
   program_loader_if #(.ADDR_W(2))  bus_b ();

   assign bus_a.rdata       = rdata;
   assign bus_a.rdata_ready = rdata_ready;
   assign bus_a.ferr        = ferr;
   assign bus_b.rdata       = rdata;
   assign bus_b.rdata_ready = rdata_ready;
   assign bus_b.ferr        = ferr;

   program_loader #(.ADDR_W(14), .BASE_ADDR(0)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));
   program_loader #(.ADDR_W(2),  .BASE_ADDR(2)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

   logic        o_we [2];
   logic [31:0] o_addr [2];
   logic [31:0] o_wdata [2];
   logic        o_fwe [2];
   logic [7:0]  o_fdata [2];
   logic        o_done [2];
   logic        o_err [2];

   assign o_we[0]    = bus_a.imem_we;
   assign o_addr[0]  = {18'd0, bus_a.imem_addr};
   assign o_wdata[0] = bus_a.imem_wdata;
   assign o_fwe[0]   = bus_a.fifo_we;
   assign o_fdata[0] = bus_a.fifo_wdata;
   assign o_done[0]  = bus_a.load_done;
   assign o_err[0]   = bus_a.err;
   assign o_we[1]    = bus_b.imem_we;
   assign o_addr[1]  = {30'd0, bus_b.imem_addr};
   assign o_wdata[1] = bus_b.imem_wdata;
   assign o_fwe[1]   = bus_b.fifo_we;
   assign o_fdata[1] = bus_b.fifo_wdata;
   assign o_done[1]  = bus_b.load_done;
   assign o_err[1]   = bus_b.err;

   // Reference model: bytes accepted since the last reset plus the expected outputs for the next sample.
   logic [7:0]  acc [$];
   logic [7:0]  seq [$];
   longint      cnt = 0;
   bit          done_m = 1'b0;
   bit          err_m [2] = '{1'b0, 1'b0};
   bit          e_we = 1'b0;
   bit          e_fwe = 1'b0;
   bit          e_rstv = 1'b1;
   logic [31:0] e_wdata = 32'd0;
   logic [31:0] e_addr [2] = '{32'd0, 32'd0};
   logic [7:0]  e_fdata = 8'd0;
   int          checks = 0;
   int          failures = 0;

   function automatic int aw(int d);
      return (d == 0) ? 14 : 2;
   endfunction

   function automatic int base(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("imem_we[%0d]", d), {31'd0, o_we[d]}, {31'd0, e_we});
         chk($sformatf("fifo_we[%0d]", d), {31'd0, o_fwe[d]}, {31'd0, e_fwe});
         chk($sformatf("load_done[%0d]", d), {31'd0, o_done[d]}, {31'd0, done_m});
         chk($sformatf("err[%0d]", d), {31'd0, o_err[d]}, {31'd0, err_m[d]});
         if (e_we) begin
            chk($sformatf("imem_addr[%0d]", d), o_addr[d], e_addr[d]);
            chk($sformatf("imem_wdata[%0d]", d), o_wdata[d], e_wdata);
         end
         if (e_fwe) begin
            chk($sformatf("fifo_wdata[%0d]", d), {24'd0, o_fdata[d]}, {24'd0, e_fdata});
         end
         if (e_rstv) begin
            chk($sformatf("rst_addr[%0d]", d), o_addr[d], 32'(base(d)));
            chk($sformatf("rst_wdata[%0d]", d), o_wdata[d], 32'd0);
            chk($sformatf("rst_fdata[%0d]", d), {24'd0, o_fdata[d]}, 32'd0);
         end
      end
   endtask

   // Stream rules: 4 size bytes (big-endian), then cnt program bytes in little-endian groups of 4, then data.
   task automatic accept(input logic [7:0] b);
      longint      p;
      int          w;
      logic [31:0] word;
      acc.push_back(b);
      if (acc.size() == 4) begin
         cnt = longint'({acc[0], acc[1], acc[2], acc[3]});
         if (cnt == 0) done_m = 1'b1;
      end else if (acc.size() > 4) begin
         p = longint'(acc.size()) - 4;
         if (p <= cnt) begin
            if ((p % 4) == 0 || p == cnt) begin
               w    = int'((p - 1) / 4);
               word = 32'd0;
               for (int j = 0; j < 4; j++) begin
                  if (longint'(4 * w + j) < p) word = word | (32'(acc[4 + 4 * w + j]) << (8 * j));
               end
               e_we    = 1'b1;
               e_wdata = word;
               for (int d = 0; d < 2; d++) begin
                  e_addr[d] = 32'((base(d) + w) % (1 << aw(d)));
                  if (w >= (1 << aw(d))) err_m[d] = 1'b1;
               end
               if (p == cnt) done_m = 1'b1;
            end
         end else begin
            e_fwe   = 1'b1;
            e_fdata = b;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit rdy, input logic [7:0] b, input bit f);
      @(negedge clk);
      check_outputs();
      e_we        = 1'b0;
      e_fwe       = 1'b0;
      e_rstv      = 1'b0;
      rstn        = !rst;
      rdata_ready = rdy;
      rdata       = b;
      ferr        = f;
      if (rst) begin
         acc.delete();
         cnt    = 0;
         done_m = 1'b0;
         err_m  = '{1'b0, 1'b0};
         e_rstv = 1'b1;
      end else if (rdy) begin
         if (f) err_m = '{1'b1, 1'b1};
         else accept(b);
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom));
   endtask

   task automatic do_reset();
      // Strobes presented while reset is held must be ignored.
      cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
      cycle(1'b1, 1'($urandom), 8'($urandom), 1'b0);
   endtask

   task automatic send(input logic [7:0] b, input bit f, input int gap);
      repeat (gap) idle();
      cycle(1'b0, 1'b1, b, f);
   endtask

   task automatic send_seq();
      foreach (seq[i]) send(seq[i], 1'b0, int'($urandom_range(0, 1)));
      repeat (2) idle();
   endtask

   initial begin
      int size;
      // Power-up reset values.
      do_reset();
      idle();

      // Two full words.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      send_seq();

      // Empty program, then one data byte to the FIFO.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h41};
      send_seq();

      // Six bytes: second word zero-padded.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_seq();

      // Framing error discarded mid-load.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h04};
      send_seq();
      send(8'hAA, 1'b1, 0);
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_seq();

      // Reset abandons a half-assembled word.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
      send_seq();
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
      send_seq();

      // Twenty bytes: the small memory wraps on the fifth write, back-to-back strobes.
      do_reset();
      seq = '{8'h00, 8'h00, 8'h00, 8'h14};
      for (int i = 0; i < 20; i++) seq.push_back(8'(8'hA0 + i));
      foreach (seq[i]) send(seq[i], 1'b0, 0);
      repeat (2) idle();

      // Randomized sessions with gaps, stray framing errors and occasional mid-stream reset.
      for (int s = 0; s < 40; s++) begin
         do_reset();
         size = int'($urandom_range(0, 22));
         seq.delete();
         seq.push_back(8'h00);
         seq.push_back(8'h00);
         seq.push_back(8'h00);
         seq.push_back(8'(size));
         for (int i = 0; i < size + int'($urandom_range(0, 4)); i++) seq.push_back(8'($urandom));
         if ((s % 7) == 3) seq = seq[0:seq.size() / 2];
         foreach (seq[i]) begin
            if ($urandom_range(0, 11) == 0) send(8'($urandom), 1'b1, int'($urandom_range(0, 1)));
            send(seq[i], 1'b0, int'($urandom_range(0, 2)));
         end
         repeat (3) idle();
      end

      @(negedge clk);
      check_outputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
